// File: rtl/limbus_nios2_oci_pkg.sv
// Shared definitions for the Nios II OCI trace path.
// Contents:
//   TW_W_DEFAULT - default trace word width in bits
//   trace_src_e  - trace source IDs; the numeric order is the packing priority
package limbus_nios2_oci_pkg;

    localparam int TW_W_DEFAULT = 36;
    localparam int NUM_SRC      = 3;

    typedef enum logic [1:0] {
        SRC_ITM = 2'd0,
        SRC_ATM = 2'd1,
        SRC_DTM = 2'd2
    } trace_src_e;

endpackage

// File: rtl/limbus_nios2_qsys_0_nios2_oci_trace_fifo_wrmux.sv
// Write-slot packer for the trace FIFO (purely combinational).
// Ports:
//   itm_valid_i, atm_valid_i, dtm_valid_i - per-source word present flags
//   n_o                                   - number of words present (0..3)
//   sel0_o, sel1_o, sel2_o                - source written to slot wrptr+0/+1/+2
//   slot_en_o                             - per-slot write enable, bit k = slot k
// Present words fill consecutive slots in itm, atm, dtm order with gaps removed.
module limbus_nios2_qsys_0_nios2_oci_trace_fifo_wrmux
    import limbus_nios2_oci_pkg::*;
(
    input  logic       itm_valid_i,
    input  logic       atm_valid_i,
    input  logic       dtm_valid_i,
    output logic [1:0] n_o,
    output trace_src_e sel0_o,
    output trace_src_e sel1_o,
    output trace_src_e sel2_o,
    output logic [2:0] slot_en_o
);

    always_comb begin
        n_o       = 2'd0;
        sel0_o    = SRC_ITM;
        sel1_o    = SRC_ITM;
        sel2_o    = SRC_ITM;
        slot_en_o = 3'b000;
        case ({dtm_valid_i, atm_valid_i, itm_valid_i})
            3'b001: begin n_o = 2'd1; slot_en_o = 3'b001; sel0_o = SRC_ITM; end
            3'b010: begin n_o = 2'd1; slot_en_o = 3'b001; sel0_o = SRC_ATM; end
            3'b100: begin n_o = 2'd1; slot_en_o = 3'b001; sel0_o = SRC_DTM; end
            3'b011: begin n_o = 2'd2; slot_en_o = 3'b011; sel0_o = SRC_ITM; sel1_o = SRC_ATM; end
            3'b101: begin n_o = 2'd2; slot_en_o = 3'b011; sel0_o = SRC_ITM; sel1_o = SRC_DTM; end
            3'b110: begin n_o = 2'd2; slot_en_o = 3'b011; sel0_o = SRC_ATM; sel1_o = SRC_DTM; end
            3'b111: begin
                n_o = 2'd3; slot_en_o = 3'b111;
                sel0_o = SRC_ITM; sel1_o = SRC_ATM; sel2_o = SRC_DTM;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/limbus_nios2_qsys_0_nios2_oci_trace_fifo.sv
// Multi-write (0..3 words/cycle), single-read trace FIFO for the OCI trace path.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   itm/atm/dtm(_valid)        - instruction/address/data trace words in
//   tw, tw_valid, tw_ready     - head-of-FIFO output with valid/ready handshake
//   fifo_cnt, fifo_empty       - occupancy (0..DEPTH) and empty flag
//   overflow, clr_overflow     - sticky "input cycle dropped" flag and its clear
// A cycle whose words do not all fit is dropped as a whole; the space check
// uses the count at the start of the cycle, so a same-cycle pop frees nothing.
module limbus_nios2_qsys_0_nios2_oci_trace_fifo
    import limbus_nios2_oci_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int TW_W  = TW_W_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             itm_valid,
    input  logic [TW_W-1:0]  itm,
    input  logic             atm_valid,
    input  logic [TW_W-1:0]  atm,
    input  logic             dtm_valid,
    input  logic [TW_W-1:0]  dtm,
    input  logic             tw_ready,
    output logic [TW_W-1:0]  tw,
    output logic             tw_valid,
    output logic [PTR_W:0]   fifo_cnt,
    output logic             fifo_empty,
    output logic             overflow,
    input  logic             clr_overflow
);

    logic [PTR_W-1:0] wrptr_q, wrptr_d;
    logic [PTR_W-1:0] rdptr_q, rdptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             overflow_q, overflow_d;

    // Storage is deliberately not reset.
    logic [TW_W-1:0]  mem [DEPTH];

    logic [1:0]       n;
    trace_src_e       slot_sel [NUM_SRC];
    logic [2:0]       slot_en;
    logic [TW_W-1:0]  slot_word [NUM_SRC];
    logic [PTR_W-1:0] slot_addr [NUM_SRC];

    logic [PTR_W:0]   free;
    logic             drop;
    logic             pop;

    limbus_nios2_qsys_0_nios2_oci_trace_fifo_wrmux u_wrmux (
        .itm_valid_i (itm_valid),
        .atm_valid_i (atm_valid),
        .dtm_valid_i (dtm_valid),
        .n_o         (n),
        .sel0_o      (slot_sel[0]),
        .sel1_o      (slot_sel[1]),
        .sel2_o      (slot_sel[2]),
        .slot_en_o   (slot_en)
    );

    // Per-slot data mux and address; addresses wrap naturally at PTR_W bits.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
        always_comb begin
            case (slot_sel[gi])
                SRC_ATM: slot_word[gi] = atm;
                SRC_DTM: slot_word[gi] = dtm;
                default: slot_word[gi] = itm;
            endcase
        end
        assign slot_addr[gi] = wrptr_q + PTR_W'(gi);
    end

    assign free = (PTR_W+1)'(DEPTH) - cnt_q;
    assign drop = (PTR_W+1)'(n) > free;
    assign pop  = tw_valid & tw_ready;

    always_comb begin
        wrptr_d    = drop ? wrptr_q : wrptr_q + PTR_W'(n);
        rdptr_d    = pop ? rdptr_q + PTR_W'(1) : rdptr_q;
        cnt_d      = cnt_q + (drop ? '0 : (PTR_W+1)'(n)) - (pop ? (PTR_W+1)'(1) : '0);
        // Set has priority over clear.
        overflow_d = drop | (overflow_q & ~clr_overflow);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrptr_q    <= '0;
            rdptr_q    <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrptr_q    <= wrptr_d;
            rdptr_q    <= rdptr_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Up to three writes per edge, always to distinct addresses.
    always_ff @(posedge clk) begin
        if (!reset && !drop) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (slot_en[k]) begin
                    mem[slot_addr[k]] <= slot_word[k];
                end
            end
        end
    end

    assign tw         = mem[rdptr_q];
    assign tw_valid   = (cnt_q != '0);
    assign fifo_empty = (cnt_q == '0);
    assign fifo_cnt   = cnt_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_limbus_nios2_qsys_0_nios2_oci_trace_fifo.sv
// Bench for the OCI trace FIFO: a queue-based model checked on every cycle,
// plus directed scenarios with literal expectations.
module tb_limbus_nios2_qsys_0_nios2_oci_trace_fifo;

    localparam int DEPTH = 16;
    localparam int TW_W  = 36;

    logic            clk = 1'b0;
    logic            reset;
    logic            itm_valid, atm_valid, dtm_valid;
    logic [TW_W-1:0] itm, atm, dtm;
    logic            tw_ready;
    logic [TW_W-1:0] tw;
    logic            tw_valid;
    logic [4:0]      fifo_cnt;
    logic            fifo_empty;
    logic            overflow;
    logic            clr_overflow;

    limbus_nios2_qsys_0_nios2_oci_trace_fifo #(.DEPTH(DEPTH), .TW_W(TW_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .itm_valid    (itm_valid),
        .itm          (itm),
        .atm_valid    (atm_valid),
        .atm          (atm),
        .dtm_valid    (dtm_valid),
        .dtm          (dtm),
        .tw_ready     (tw_ready),
        .tw           (tw),
        .tw_valid     (tw_valid),
        .fifo_cnt     (fifo_cnt),
        .fifo_empty   (fifo_empty),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;
    int unsigned seq = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO contents as a queue, overflow as a bit.
    logic [TW_W-1:0] q[$];
    bit              m_ovf = 0;

    always @(posedge clk) begin
        int  n;
        bit  drop;
        bit  do_pop;
        if (reset) begin
            q.delete();
            m_ovf = 0;
        end else begin
            n      = int'(itm_valid) + int'(atm_valid) + int'(dtm_valid);
            drop   = n > (DEPTH - q.size());
            do_pop = tw_ready && (q.size() > 0);
            if (do_pop) void'(q.pop_front());
            if (!drop) begin
                if (itm_valid) q.push_back(itm);
                if (atm_valid) q.push_back(atm);
                if (dtm_valid) q.push_back(dtm);
            end
            m_ovf = drop ? 1'b1 : (clr_overflow ? 1'b0 : m_ovf);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("m_cnt",   64'(fifo_cnt),   64'(q.size()));
            chk("m_empty", 64'(fifo_empty), 64'(q.size() == 0));
            chk("m_valid", 64'(tw_valid),   64'(q.size() != 0));
            chk("m_ovf",   64'(overflow),   64'(m_ovf));
            if (q.size() != 0) chk("m_tw", 64'(tw), 64'(q[0]));
        end
    end

    function automatic logic [TW_W-1:0] nw();
        seq++;
        return {4'h9, 32'(seq)};
    endfunction

    // Drive one cycle's inputs at a falling edge, return after the next falling edge.
    task automatic step(input bit iv, input bit av, input bit dv, input bit rdy,
                        input bit clr, input bit rst);
        reset = rst; itm_valid = iv; atm_valid = av; dtm_valid = dv;
        itm = nw(); atm = nw(); dtm = nw();
        tw_ready = rdy; clr_overflow = clr;
        @(negedge clk);
    endtask

    task automatic push3w(input logic [TW_W-1:0] a, input logic [TW_W-1:0] b,
                          input logic [TW_W-1:0] c, input bit iv, input bit av, input bit dv);
        reset = 0; itm_valid = iv; atm_valid = av; dtm_valid = dv;
        itm = a; atm = b; dtm = c; tw_ready = 0; clr_overflow = 0;
        @(negedge clk);
    endtask

    localparam logic [TW_W-1:0] WA = 36'hA_AAAA_0001;
    localparam logic [TW_W-1:0] WB = 36'hB_BBBB_0002;
    localparam logic [TW_W-1:0] WC = 36'hC_CCCC_0003;
    localparam logic [TW_W-1:0] WX = 36'h1_0000_00A1;
    localparam logic [TW_W-1:0] WY = 36'h2_0000_00B2;
    localparam logic [TW_W-1:0] WZ = 36'h3_0000_00C3;

    initial begin
        reset = 1; itm_valid = 0; atm_valid = 0; dtm_valid = 0;
        itm = '0; atm = '0; dtm = '0; tw_ready = 0; clr_overflow = 0;
        @(negedge clk);
        check_en = 1;
        step(0,0,0,0,0,1);
        step(0,0,0,0,0,0);
        chk("rst_cnt",   64'(fifo_cnt),   64'd0);
        chk("rst_empty", 64'(fifo_empty), 64'd1);
        chk("rst_valid", 64'(tw_valid),   64'd0);
        chk("rst_ovf",   64'(overflow),   64'd0);

        // itm + dtm packed into consecutive slots
        push3w(WA, WB, WC, 1, 0, 1);
        chk("pk_cnt", 64'(fifo_cnt), 64'd2);
        chk("pk_tw0", 64'(tw), 64'(WA));
        step(0,0,0,1,0,0);
        chk("pk_tw1", 64'(tw), 64'(WC));
        step(0,0,0,1,0,0);
        chk("pk_empty", 64'(tw_valid), 64'd0);

        // Fill with three words per cycle
        for (int i = 1; i <= 5; i++) begin
            step(1,1,1,0,0,0);
            chk("fill_cnt", 64'(fifo_cnt), 64'(3*i));
        end
        step(1,1,1,0,0,0);
        chk("drop_cnt", 64'(fifo_cnt), 64'd15);
        chk("drop_ovf", 64'(overflow), 64'd1);
        step(1,0,0,0,0,0);
        chk("full_cnt", 64'(fifo_cnt), 64'd16);

        // Clear, then pop while full with a new word: pop not credited
        step(0,0,0,0,1,0);
        chk("clr_ovf", 64'(overflow), 64'd0);
        step(1,0,0,1,0,0);
        chk("fullpop_cnt", 64'(fifo_cnt), 64'd15);
        chk("fullpop_ovf", 64'(overflow), 64'd1);

        // Set and clear in the same cycle: set wins
        step(0,0,0,0,1,0);
        step(1,1,1,0,1,0);
        chk("setwin_ovf", 64'(overflow), 64'd1);
        step(0,0,0,0,1,0);
        chk("clr2_ovf", 64'(overflow), 64'd0);

        // Mid-stream reset with 5 words stored
        step(0,0,0,0,0,1);
        step(1,1,1,0,0,0);
        step(1,0,1,0,0,0);
        chk("mid_cnt5", 64'(fifo_cnt), 64'd5);
        step(0,0,0,0,0,1);
        chk("mid_cnt", 64'(fifo_cnt), 64'd0);
        chk("mid_valid", 64'(tw_valid), 64'd0);

        // Wrap-around: 14 in, 14 out, then X,Y,Z land at slots 14,15,0
        for (int i = 0; i < 4; i++) step(1,1,1,0,0,0);
        step(1,1,0,0,0,0);
        chk("wr_pre", 64'(fifo_cnt), 64'd14);
        for (int i = 0; i < 14; i++) step(0,0,0,1,0,0);
        chk("wr_drained", 64'(fifo_cnt), 64'd0);
        push3w(WX, WY, WZ, 1, 1, 1);
        chk("wr_cnt", 64'(fifo_cnt), 64'd3);
        chk("wr_slot14", 64'(dut.mem[14]), 64'(WX));
        chk("wr_slot15", 64'(dut.mem[15]), 64'(WY));
        chk("wr_slot0",  64'(dut.mem[0]),  64'(WZ));
        chk("wr_tw0", 64'(tw), 64'(WX));
        step(0,0,0,1,0,0);
        chk("wr_tw1", 64'(tw), 64'(WY));
        step(0,0,0,1,0,0);
        chk("wr_tw2", 64'(tw), 64'(WZ));
        step(0,0,0,1,0,0);
        chk("wr_end", 64'(tw_valid), 64'd0);

        // Mixed traffic checked against the model
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
                 ($urandom_range(0,3) != 0), ($urandom_range(0,7) == 0),
                 ($urandom_range(0,99) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
